stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of stack entries; power of two, minimum 2.
REQ-003 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 push  input  1  write din onto the stack this cycle.
REQ-007 pop  input  1  remove the top entry this cycle.
REQ-008 tos  input  1  top-of-stack read request; no state change.
REQ-009 din  input  WIDTH  data to push.
REQ-010 err_clr  input  1  clears the sticky error flags.
REQ-011 dout  output  WIDTH  current top entry; combinational from stored state.
REQ-012 count  output  AW+1  number of valid entries, 0..DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  count == DEPTH.
REQ-015 ovf  output  1  sticky overflow flag.
REQ-016 udf  output  1  sticky underflow flag.

Function
REQ-017 The stack SHALL hold entries in a DEPTH x WIDTH register array, addressed by pointer sp (AW+1 bits); count SHALL equal sp.
REQ-018 dout SHALL equal mem[sp-1] when not empty and 0 when empty, independent of pop/tos. A pop therefore presents the popped value during the same cycle the datapath loads it.
REQ-019 tos SHALL have no effect on sp, mem or the flags; it only qualifies dout for the datapath.
REQ-020 Operating mode, decided per cycle from {push,pop}:
- IDLE (00): hold.
- PUSH (10): mem[sp] <= din, sp <= sp+1.
- POP (01): sp <= sp-1.
- REPLACE (11): mem[sp-1] <= din, sp unchanged.
REQ-021 Push when full SHALL be dropped: mem and sp unchanged, ovf <= 1.
REQ-022 Pop when empty SHALL be dropped: sp stays 0, dout stays 0, udf <= 1.
REQ-023 REPLACE when empty SHALL behave as PUSH: mem[0] <= din, sp <= 1, no flag.
REQ-024 REPLACE when full SHALL proceed normally; ovf is not set.
REQ-025 ovf and udf SHALL remain set until err_clr or reset.
REQ-026 err_clr in the same cycle as a new error SHALL leave the flag set (set wins).
REQ-027 Pointer arithmetic SHALL never wrap: sp is bounded to 0..DEPTH by REQ-021/022.
REQ-028 Latency: push/pop effects SHALL be visible on dout/count in the cycle after the edge that samples them.
REQ-029 Entries above sp SHALL be don't-care and never observable on dout.

Reset
REQ-030 While rst is low: sp=0, count=0, empty=1, full=0, ovf=0, udf=0, dout=0, all asynchronously.
REQ-031 Array contents need not be reset; they are unobservable while empty.
REQ-032 Reset asserted mid-operation SHALL discard all entries; the first edge after release SHALL act on inputs normally.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 -> count=3, dout=0x33; pop -> dout=0x22 in the next cycle, count=2.
REQ-034 Hold pop with tos=0 at count=2 (top 0x22) -> dout=0x22 in the pop cycle, and ldA-style capture gets 0x22; tos alone for 3 cycles -> count and dout unchanged.
REQ-035 Fill to DEPTH=8 with 0x01..0x08 -> full=1; push 0xFF -> count=8, dout=0x08, ovf=1; err_clr -> ovf=0.
REQ-036 From empty, pop -> udf=1, count=0, dout=0; push+pop with din 0x5A while empty -> count=1, dout=0x5A, udf unchanged.
REQ-037 With count=2, top 0x22: push+pop with din 0x77 -> count=2, dout=0x77, next entry intact after a pop (dout=0x11).
REQ-038 With count=3, drive rst low between edges -> outputs reach reset values immediately; after release, push 0x44 -> count=1, dout=0x44.

Source files
------------

// File: rtl/stack_unit.sv
// LIFO stack over a DEPTH x WIDTH register array with sticky overflow/underflow flags.
// push+pop in one cycle replaces the top entry (or pushes when the stack is empty).
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] SP_FULL = DEPTH[AW:0];
    localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [AW:0]      sp_m1;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    // tos only qualifies dout for the consumer; the stack itself ignores it.
    logic unused_tos;
    assign unused_tos = tos;

    assign sp_m1 = sp_q - SP_ONE;
    assign empty = (sp_q == '0);
    assign full  = (sp_q == SP_FULL);
    assign count = sp_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
    assign dout  = empty ? '0 : mem_q[sp_m1[AW-1:0]];

    always_comb begin
        sp_d    = sp_q;
        ovf_d   = ovf_q & ~err_clr;
        udf_d   = udf_q & ~err_clr;
        wr_en   = 1'b0;
        wr_addr = sp_q[AW-1:0];
        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + SP_ONE;
                end
            end
            2'b01: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    sp_d = sp_m1;
                end
            end
            2'b11: begin
                // Replace on an empty stack degenerates into a plain push into slot 0.
                wr_en = 1'b1;
                if (empty) begin
                    wr_addr = '0;
                    sp_d    = SP_ONE;
                end else begin
                    wr_addr = sp_m1[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Array contents are unobservable while empty, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= din;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus random traffic against a queue model.
module tb_stack_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [AW:0]      count;
    logic             empty, full, ovf, udf;

    int checks = 0;
    int errors = 0;
    int q[$];
    bit m_ovf, m_udf;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .err_clr(err_clr), .dout(dout), .count(count), .empty(empty),
        .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    function automatic int exp_dout();
        return (q.size() == 0) ? 0 : q[q.size()-1];
    endfunction

    // Drive one cycle of inputs, advance the reference model, return at posedge+1.
    task automatic cycle(input bit pu, input bit po, input bit t, input logic [7:0] d, input bit ec);
        push = pu; pop = po; tos = t; din = d; err_clr = ec;
        @(posedge clk);
        if (ec) begin m_ovf = 0; m_udf = 0; end
        if (pu && !po) begin
            if (q.size() == DEPTH) m_ovf = 1; else q.push_back(int'(d));
        end else if (!pu && po) begin
            if (q.size() == 0) m_udf = 1; else void'(q.pop_back());
        end else if (pu && po) begin
            if (q.size() == 0) q.push_back(int'(d)); else q[q.size()-1] = int'(d);
        end
        #1;
        push = 0; pop = 0; tos = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        q.delete();
        m_ovf = 0; m_udf = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0h exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %0b%0b exp 00", ovf, udf); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h exp 0", dout); end
        @(negedge clk);
        rst = 1'b1;
        q.delete(); m_ovf = 0; m_udf = 0;
    endtask

    task automatic test_push_pop();
        do_reset();
        cycle(1, 0, 0, 8'h11, 0);
        cycle(1, 0, 0, 8'h22, 0);
        cycle(1, 0, 0, 8'h33, 0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count got %0d exp 3", count); end
        checks++; if (dout !== 8'h33) begin errors++; $display("FAIL pp_dout got %0h exp 33", dout); end
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (dout !== 8'h22) begin errors++; $display("FAIL pop_dout got %0h exp 22", dout); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL pop_count got %0d exp 2", count); end
    endtask

    task automatic test_pop_tos();
        logic [7:0] captured;
        logic [AW:0] cnt0;
        logic [7:0] dout0;
        // state from previous test: count 2, top 0x22
        push = 0; pop = 1; tos = 0;
        #1 captured = dout;
        checks++; if (captured !== 8'h22) begin errors++; $display("FAIL pop_cycle_dout got %0h exp 22", captured); end
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL after_pop_dout got %0h exp 11", dout); end
        cnt0 = count; dout0 = dout;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'hEE, 0);
        checks++; if (count !== 4'd1 || cnt0 !== 4'd1) begin errors++; $display("FAIL tos_count got %0d exp 1", count); end
        checks++; if (dout !== 8'h11 || dout0 !== 8'h11) begin errors++; $display("FAIL tos_dout got %0h exp 11", dout); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 0, 8'(i), 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", full); end
        cycle(1, 0, 0, 8'hFF, 0);
        checks++; if (count !== 4'd8 || dout !== 8'h08) begin errors++; $display("FAIL ovf_state got %0d/%0h exp 8/08", count, dout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", ovf); end
        cycle(0, 0, 0, 8'h00, 1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b exp 0", ovf); end
        cycle(1, 1, 0, 8'hAB, 0);
        checks++; if (count !== 4'd8 || dout !== 8'hAB || ovf !== 1'b0) begin errors++; $display("FAIL repl_full got %0d/%0h/%0b exp 8/ab/0", count, dout, ovf); end
        cycle(1, 0, 0, 8'hCC, 1);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b exp 1", ovf); end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (udf !== 1'b1 || count !== 4'd0 || dout !== 8'h00) begin errors++; $display("FAIL udf got %0b/%0d/%0h exp 1/0/00", udf, count, dout); end
        cycle(1, 1, 0, 8'h5A, 0);
        checks++; if (count !== 4'd1 || dout !== 8'h5A || udf !== 1'b1) begin errors++; $display("FAIL repl_empty got %0d/%0h/%0b exp 1/5a/1", count, dout, udf); end
    endtask

    task automatic test_replace();
        do_reset();
        cycle(1, 0, 0, 8'h11, 0);
        cycle(1, 0, 0, 8'h22, 0);
        cycle(1, 1, 0, 8'h77, 0);
        checks++; if (count !== 4'd2 || dout !== 8'h77) begin errors++; $display("FAIL replace got %0d/%0h exp 2/77", count, dout); end
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL replace_below got %0h exp 11", dout); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 0, 0, 8'h11, 0);
        cycle(1, 0, 0, 8'h22, 0);
        cycle(1, 0, 0, 8'h33, 0);
        #2 rst = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL async_rst got %0d/%0b/%0b/%0h exp 0/1/0/00", count, empty, full, dout); end
        q.delete(); m_ovf = 0; m_udf = 0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 0, 0, 8'h44, 0);
        checks++; if (count !== 4'd1 || dout !== 8'h44) begin errors++; $display("FAIL post_rst got %0d/%0h exp 1/44", count, dout); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1,
                  8'($urandom), $urandom_range(0, 99) < 6);
            checks++;
            if ({28'b0, count} !== q.size() || {24'b0, dout} !== exp_dout()
                || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)
                || ovf !== m_ovf || udf !== m_udf) begin
                errors++;
                $display("FAIL rand[%0d] got c=%0d d=%0h e=%0b f=%0b o=%0b u=%0b exp c=%0d d=%0h o=%0b u=%0b",
                         i, count, dout, empty, full, ovf, udf, q.size(), exp_dout(), m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_pop_tos();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
